// File: rtl/ufm_read_arbiter_if.sv
// Requester bus plus altufm parallel-read port shared by ufm_read_arbiter.
// slave  : the arbiter itself
// master : the requesters and the altufm macro driving the arbiter
interface ufm_read_arbiter_if #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    // requester side
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] reqAddr;
    logic [NREQ*4-1:0]      reqLen;
    logic [NREQ-1:0]        grant;
    logic [DATA_W-1:0]      rdData;
    logic [NREQ-1:0]        rdValid;
    logic [NREQ-1:0]        done;
    logic [NREQ-1:0]        err;
    // altufm side
    logic [ADDR_W-1:0]      ufmAddr;
    logic                   ufmnRead;
    logic                   ufmDataValid;
    logic [DATA_W-1:0]      ufmDataOut;

    modport slave (
        input  req, reqAddr, reqLen, ufmDataValid, ufmDataOut,
        output grant, rdData, rdValid, done, err, ufmAddr, ufmnRead
    );

    modport master (
        output req, reqAddr, reqLen, ufmDataValid, ufmDataOut,
        input  grant, rdData, rdValid, done, err, ufmAddr, ufmnRead
    );
endinterface

// File: rtl/ufm_read_arbiter.sv
// Round-robin arbiter sharing the altufm parallel-read port between NREQ
// burst requesters, with a per-word watchdog that aborts a stalled burst.
module ufm_read_arbiter #(
    parameter int NREQ    = 2,
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                CLK_10MHZ,
    input  logic                nReset,
    ufm_read_arbiter_if.slave   bus
);
    localparam int PTR_W = $clog2(NREQ);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NREQ - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t             state_q, state_d;
    logic [NREQ-1:0]    grant_q, grant_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic [NREQ-1:0]    rd_valid_q, rd_valid_d;
    logic [NREQ-1:0]    done_q, done_d;
    logic [NREQ-1:0]    err_q, err_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               nread_q, nread_d;
    logic [PTR_W-1:0]   rr_q, rr_d;         // last granted requester, also the current owner
    logic [4:0]         rem_q, rem_d;       // words still to fetch, 1..16
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               drop_q, drop_d;     // owner released req during this burst
    logic               dv_q;

    logic [ADDR_W-1:0]  req_addr [NREQ];
    logic [3:0]         req_len  [NREQ];
    logic [PTR_W-1:0]   pick, cand;
    logic               found;
    logic               dv_rise, dv_fall, owner_req, dropped;

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign req_addr[g] = bus.reqAddr[g*ADDR_W +: ADDR_W];
        assign req_len[g]  = bus.reqLen[g*4 +: 4];
    end

    assign dv_rise   =  bus.ufmDataValid & ~dv_q;
    assign dv_fall   = ~bus.ufmDataValid &  dv_q;
    assign owner_req = bus.req[rr_q];
    assign dropped   = drop_q | ~owner_req;

    // Round-robin search: first requesting index after the last winner.
    always_comb begin
        cand  = rr_q;
        pick  = rr_q;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (cand == LAST_PTR) ? '0 : cand + 1'b1;
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Burst sequencing: next-state and next-output values.
    always_comb begin
        // NOTE: every target gets a default first, so no path leaves a latch behind.
        state_d    = state_q;
        grant_d    = grant_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = '0;
        done_d     = '0;
        err_d      = '0;
        addr_d     = addr_q;
        nread_d    = nread_q;
        rr_d       = rr_q;
        rem_d      = rem_q;
        wd_d       = wd_q;
        drop_d     = drop_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    rr_d          = pick;
                    addr_d        = req_addr[pick];
                    rem_d         = (req_len[pick] == 4'd0) ? 5'd16 : {1'b0, req_len[pick]};
                    nread_d       = 1'b0;
                    wd_d          = '0;
                    drop_d        = 1'b0;
                    state_d       = ISSUE;
                end
            end
            ISSUE, WAIT: begin
                wd_d = wd_q + 1'b1;
                if (!owner_req) drop_d = 1'b1;
                if (state_q == ISSUE && dv_fall) begin
                    nread_d = 1'b1;
                    wd_d    = '0;
                    state_d = WAIT;
                end else if (state_q == WAIT && dv_rise) begin
                    // The word is consumed from the UFM even when nobody wants it.
                    addr_d = addr_q + 1'b1;
                    if (dropped) begin
                        grant_d = '0;
                        state_d = IDLE;
                    end else begin
                        rd_data_d        = bus.ufmDataOut;
                        rd_valid_d[rr_q] = 1'b1;
                        rem_d            = rem_q - 1'b1;
                        if (rem_q == 5'd1) begin
                            state_d = DONE;
                        end else begin
                            nread_d = 1'b0;
                            wd_d    = '0;
                            state_d = ISSUE;
                        end
                    end
                end else if (wd_q == WD_LAST) begin
                    nread_d = 1'b1;
                    grant_d = '0;
                    state_d = IDLE;
                    if (!dropped) err_d[rr_q] = 1'b1;
                end
            end
            DONE: begin
                done_d[rr_q] = 1'b1;
                grant_d      = '0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset forces the UFM read strobe inactive.
    always_ff @(posedge CLK_10MHZ or negedge nReset) begin
        if (!nReset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= '0;
            done_q     <= '0;
            err_q      <= '0;
            addr_q     <= '0;
            nread_q    <= 1'b1;
            rr_q       <= LAST_PTR;
            rem_q      <= '0;
            wd_q       <= '0;
            drop_q     <= 1'b0;
            dv_q       <= 1'b1;   // altufm idles with data_valid high
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q    <= state_d;
            grant_q    <= grant_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            nread_q    <= nread_d;
            rr_q       <= rr_d;
            rem_q      <= rem_d;
            wd_q       <= wd_d;
            drop_q     <= drop_d;
            dv_q       <= bus.ufmDataValid;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.rdData   = rd_data_q;
    assign bus.rdValid  = rd_valid_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.ufmAddr  = addr_q;
    assign bus.ufmnRead = nread_q;
endmodule

// File: tb/tb_ufm_read_arbiter.sv
// Scoreboard bench for ufm_read_arbiter: stimulus pushes expected words and
// completion events, a negedge monitor pops and compares them as they appear.
module tb_ufm_read_arbiter;
    localparam int NREQ    = 2;
    localparam int ADDR_W  = 9;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 255;

    typedef enum int {EV_WORD = 0, EV_DONE = 1, EV_ERR = 2} ev_kind_t;
    typedef struct {
        ev_kind_t          kind;
        int                idx;
        logic [DATA_W-1:0] data;
    } ev_t;

    logic clk     = 1'b0;
    logic n_reset = 1'b0;
    bit   stuck   = 1'b0;      // UFM model never answers while set

    int   tests = 0;
    int   fails = 0;
    ev_t  sb[$];
    int   last_win;             // reference round-robin memory
    int   rdv_cnt [NREQ];
    int   overlap_cnt = 0;

    ufm_read_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ufm_read_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK_10MHZ (clk),
        .nReset    (n_reset),
        .bus       (bus)
    );

    // 10 MHz clock.
    always #50 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] word_data(input logic [ADDR_W-1:0] a);
        return {a[7:0], ~a[7:0]};
    endfunction

    function automatic int burst_words(input logic [3:0] len);
        return (len == 4'd0) ? 16 : int'(len);
    endfunction

    function automatic int next_winner(input logic [NREQ-1:0] mask, input int after);
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (after + k) % NREQ;
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic push_event(input ev_kind_t kind, input int idx, input logic [DATA_W-1:0] data);
        ev_t e;
        e.kind = kind;
        e.idx  = idx;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic push_words(input int idx, input logic [ADDR_W-1:0] addr, input int n);
        logic [ADDR_W-1:0] a;
        a = addr;
        for (int w = 0; w < n; w++) begin
            push_event(EV_WORD, idx, word_data(a));
            a = a + 1'b1;
        end
    endtask

    // altufm behaviour: data_valid falls 2 cycles after nread low, rises 5 later.
    initial begin
        bit                active;
        int                cnt;
        logic [ADDR_W-1:0] cap;
        active           = 1'b0;
        cnt              = 0;
        cap              = '0;
        bus.ufmDataValid = 1'b1;
        bus.ufmDataOut   = '0;
        forever begin
            @(negedge clk);
            if (!n_reset) begin
                active           = 1'b0;
                bus.ufmDataValid = 1'b1;
            end else if (!active) begin
                if (!bus.ufmnRead && !stuck) begin
                    active = 1'b1;
                    cnt    = 0;
                    cap    = bus.ufmAddr;
                end
            end else begin
                cnt++;
                if (cnt == 2) bus.ufmDataValid = 1'b0;
                if (cnt == 7) begin
                    bus.ufmDataOut   = word_data(cap);
                    bus.ufmDataValid = 1'b1;
                    active           = 1'b0;
                end
            end
        end
    end

    // Monitor: every strobe from the DUT is matched against the scoreboard head.
    always @(negedge clk) begin
        logic [3*NREQ-1:0] ev, exp_ev;
        ev_t               e;
        if (n_reset) begin
            if ($countones(bus.grant) > 1) overlap_cnt++;
            ev = {bus.err, bus.done, bus.rdValid};
            if (ev != '0) begin
                for (int i = 0; i < NREQ; i++) if (bus.rdValid[i]) rdv_cnt[i]++;
                check("single_strobe", $countones(ev), 1);
                if (sb.size() == 0) begin
                    check("unexpected_strobe", ev, 0);
                end else begin
                    e      = sb.pop_front();
                    exp_ev = '0;
                    exp_ev[int'(e.kind)*NREQ + e.idx] = 1'b1;
                    check("strobe_kind", ev, exp_ev);
                    if (e.kind == EV_WORD) begin
                        check("rd_data", bus.rdData, e.data);
                        check("grant_during_word", bus.grant, onehot(e.idx));
                    end
                end
            end
        end
    end

    // Serve the requesters in mask; each drops req right after its done.
    task automatic run_bursts(input logic [NREQ-1:0] mask,
                              input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                              input logic [3:0] l0, input logic [3:0] l1);
        logic [ADDR_W-1:0] addr [NREQ];
        logic [3:0]        len  [NREQ];
        logic [NREQ-1:0]   left, pending;
        int                w, first;
        addr[0] = a0; addr[1] = a1;
        len[0]  = l0; len[1]  = l1;
        first   = next_winner(mask, last_win);
        left    = mask;
        while (left != '0) begin
            w = next_winner(left, last_win);
            push_words(w, addr[w], burst_words(len[w]));
            push_event(EV_DONE, w, '0);
            left[w]  = 1'b0;
            last_win = w;
        end
        for (int i = 0; i < NREQ; i++) begin
            bus.reqAddr[i*ADDR_W +: ADDR_W] = addr[i];
            bus.reqLen[i*4 +: 4]            = len[i];
        end
        bus.req = bus.req | mask;
        pending = mask;
        @(negedge clk);
        check("grant_latency", bus.grant, onehot(first));
        check("nread_latency", bus.ufmnRead, 1'b0);
        for (int c = 0; c < 1500 && pending != '0; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (pending[i] && bus.done[i]) begin
                    pending[i] = 1'b0;
                    bus.req[i] = 1'b0;
                end
            end
        end
        check("burst_complete", pending, '0);
    endtask

    // Both requesters hold req: grants rotate 0,1,0; the third burst is abandoned.
    task automatic contention_test();
        logic [NREQ-1:0] grants[$];
        logic [NREQ-1:0] prev;
        int              w [3];
        w[0] = next_winner(2'b11, last_win);
        w[1] = next_winner(2'b11, w[0]);
        w[2] = next_winner(2'b11, w[1]);
        bus.reqAddr = {9'h100, 9'h020};
        bus.reqLen  = {4'd2, 4'd2};
        push_words(w[0], w[0] == 0 ? 9'h020 : 9'h100, 2);
        push_event(EV_DONE, w[0], '0);
        push_words(w[1], w[1] == 0 ? 9'h020 : 9'h100, 2);
        push_event(EV_DONE, w[1], '0);
        bus.req = 2'b11;
        prev    = '0;
        for (int c = 0; c < 400 && grants.size() < 3; c++) begin
            @(negedge clk);
            if (bus.grant != '0 && prev == '0) grants.push_back(bus.grant);
            prev = bus.grant;
        end
        bus.req  = '0;
        last_win = w[2];
        check("cont_grant_count", grants.size(), 3);
        for (int k = 0; k < grants.size(); k++) check("cont_grant_order", grants[k], onehot(w[k]));
        repeat (20) @(negedge clk);
        check("cont_idle_grant", bus.grant, '0);
        check("cont_idle_nread", bus.ufmnRead, 1'b1);
    endtask

    // UFM never answers: err after TIMEOUT cycles, then a normal burst.
    task automatic timeout_test();
        int n;
        bit seen;
        rdv_cnt = '{default: 0};
        stuck   = 1'b1;
        push_event(EV_ERR, 0, '0);
        bus.reqAddr[0 +: ADDR_W] = 9'h050;
        bus.reqLen[0 +: 4]       = 4'd3;
        bus.req[0]               = 1'b1;
        @(negedge clk);
        check("to_grant", bus.grant, 2'b01);
        n    = 0;
        seen = 1'b0;
        while (n < 400 && !seen) begin
            @(negedge clk);
            n++;
            if (bus.err[0]) seen = 1'b1;
        end
        bus.req[0] = 1'b0;
        stuck      = 1'b0;
        last_win   = 0;
        check("to_err_seen", seen, 1'b1);
        check("to_latency", n, TIMEOUT);
        check("to_nread", bus.ufmnRead, 1'b1);
        check("to_grant_clear", bus.grant, '0);
        check("to_no_words", rdv_cnt[0], 0);
        @(negedge clk);
        run_bursts(2'b01, 9'h051, 9'h000, 4'd2, 4'd0);
    endtask

    // Requester 0 gives up during word 3 of 6.
    task automatic drop_test();
        rdv_cnt = '{default: 0};
        push_words(0, 9'h040, 2);
        last_win = 0;
        bus.reqAddr[0 +: ADDR_W] = 9'h040;
        bus.reqLen[0 +: 4]       = 4'd6;
        bus.req[0]               = 1'b1;
        for (int c = 0; c < 100 && rdv_cnt[0] < 2; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        bus.req[0] = 1'b0;
        repeat (20) @(negedge clk);
        check("drop_words", rdv_cnt[0], 2);
        check("drop_grant", bus.grant, '0);
        check("drop_nread", bus.ufmnRead, 1'b1);
    endtask

    // Reset lands while waiting for a word; afterwards requester 1 is served.
    task automatic reset_test();
        bit in_wait;
        bus.reqAddr[0 +: ADDR_W] = 9'h0A0;
        bus.reqLen[0 +: 4]       = 4'd4;
        bus.req[0]               = 1'b1;
        in_wait = 1'b0;
        for (int c = 0; c < 50 && !in_wait; c++) begin
            @(negedge clk);
            if (bus.grant == 2'b01 && bus.ufmnRead) in_wait = 1'b1;
        end
        check("rst_reached_wait", in_wait, 1'b1);
        #10 n_reset = 1'b0;
        #1;
        check("rst_async_nread", bus.ufmnRead, 1'b1);
        check("rst_async_grant", bus.grant, '0);
        check("rst_async_addr", bus.ufmAddr, '0);
        sb.delete();
        bus.req  = '0;
        last_win = NREQ - 1;
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        run_bursts(2'b10, 9'h000, 9'h030, 4'd0, 4'd3);
    endtask

    initial begin
        logic [NREQ-1:0]   mask;
        logic [ADDR_W-1:0] ra0, ra1;
        logic [3:0]        rl0, rl1;
        bus.req     = '0;
        bus.reqAddr = '0;
        bus.reqLen  = '0;
        rdv_cnt     = '{default: 0};
        last_win    = NREQ - 1;
        repeat (3) @(negedge clk);
        check("reset_grant", bus.grant, '0);
        check("reset_rd_valid", bus.rdValid, '0);
        check("reset_done", bus.done, '0);
        check("reset_err", bus.err, '0);
        check("reset_rd_data", bus.rdData, '0);
        check("reset_ufm_addr", bus.ufmAddr, '0);
        check("reset_nread", bus.ufmnRead, 1'b1);
        n_reset = 1'b1;
        @(negedge clk);

        contention_test();

        rdv_cnt = '{default: 0};
        run_bursts(2'b01, 9'h008, 9'h000, 4'd6, 4'd0);
        check("single_words", rdv_cnt[0], 6);
        check("single_end_addr", bus.ufmAddr, 9'h00E);

        rdv_cnt = '{default: 0};
        run_bursts(2'b10, 9'h000, 9'h1FE, 4'd0, 4'd0);
        check("wrap_words", rdv_cnt[1], 16);
        check("wrap_end_addr", bus.ufmAddr, 9'h00E);

        timeout_test();
        drop_test();
        reset_test();

        for (int it = 0; it < 12; it++) begin
            mask = NREQ'($urandom_range(1, 3));
            ra0  = ADDR_W'($urandom);
            ra1  = ADDR_W'($urandom);
            rl0  = 4'($urandom_range(0, 15));
            rl1  = 4'($urandom_range(0, 15));
            run_bursts(mask, ra0, ra1, rl0, rl1);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        check("grant_never_overlaps", overlap_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
